// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit hex display driver with
// frame-boundary double buffering of the shown value.
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int   IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int   CW      = $clog2(REFRESH_DIV);
    localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_OFF  = (AN_ACTIVE_LOW != 0);

    logic [CW-1:0]           cnt;
    logic                    tick;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic                    pend;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;
    logic [NUM_DIGITS-1:0]   dark;
    logic                    hz;
    logic [3:0]              nib;
    logic [6:0]              seg_on;
    logic                    dp_on;
    logic [NUM_DIGITS-1:0]   an_on;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h7E;
            4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;
            4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;
            4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;
            4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;
            4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;
            4'hF: hex7 = 7'h47;
        endcase
    endfunction

    assign tick = en && (cnt == CW'(REFRESH_DIV - 1));
    assign wrap = tick && (digit_idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (en) begin
                cnt <= tick ? '0 : cnt + CW'(1);
                if (tick)
                    digit_idx <= wrap ? '0 : digit_idx + IW'(1);
            end
        end
    end

    // Display buffer only changes at a frame wrap so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend       <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else begin
            if (wrap && pend) begin
                disp_val   <= pend_val;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
            end
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_blank <= blank;
                pend       <= 1'b1;
            end else if (wrap) begin
                pend       <= 1'b0;
            end
        end
    end

    always_comb begin
        dark = disp_blank;
        hz   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hz = hz && (disp_val[4*i +: 4] == 4'h0);
            if (LZ_BLANK != 0 && i != 0 && hz)
                dark[i] = 1'b1;
        end
    end

    assign nib = disp_val[{digit_idx, 2'b00} +: 4];

    always_comb begin
        seg_on = '0;
        dp_on  = 1'b0;
        an_on  = '0;
        if (en) begin
            an_on[digit_idx] = 1'b1;
            if (!dark[digit_idx]) begin
                seg_on = hex7(nib);
                dp_on  = disp_dp[digit_idx];
            end
        end
    end

    // Polarity is applied only here, at the pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= {7{SEG_OFF}};
            dp  <= SEG_OFF;
            an  <= {NUM_DIGITS{AN_OFF}};
        end else begin
            seg <= seg_on ^ {7{SEG_OFF}};
            dp  <= dp_on ^ SEG_OFF;
            an  <= an_on ^ {NUM_DIGITS{AN_OFF}};
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Randomized bench for seven_segment_scan_driver against a
// frame/time arithmetic reference model.
module tb_seven_segment_scan_driver;

    localparam int N = 4;
    localparam int R = 4;
    localparam int F = N * R;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic [1:0]  idx0, idx1;
    logic        fd0, fd1;

    seven_segment_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW(1), .LZ_BLANK(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .value(value), .dp_in(dp_in), .blank(blank),
        .seg(seg0), .dp(dp0), .an(an0),
        .digit_idx(idx0), .frame_done(fd0)
    );

    seven_segment_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW(1), .LZ_BLANK(1)
    ) u_dut_lz (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .value(value), .dp_in(dp_in), .blank(blank),
        .seg(seg1), .dp(dp1), .an(an1),
        .digit_idx(idx1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] hex7 [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    int vectors = 0;
    int errors  = 0;

    // model: t = enabled cycles since reset
    int          t;
    logic [15:0] pv, dv;
    logic [3:0]  pdp, pbl, ddp, dbl;
    bit          pend;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_dp0, e_dp1, e_fd;
    logic [3:0]  e_an;
    logic [1:0]  e_idx;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_dark(input logic [15:0] v,
                                   input logic [3:0] bl,
                                   input int d, input bit lz);
        return bl[d] || (lz && d != 0 && (v >> (4 * d)) == 16'h0);
    endfunction

    task automatic model_reset();
        t = 0; pv = '0; dv = '0; pdp = '0; pbl = '0;
        ddp = '0; dbl = '0; pend = 1'b0;
        e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp0 = 1'b1; e_dp1 = 1'b1;
        e_an = 4'hF; e_fd = 1'b0; e_idx = 2'd0;
    endtask

    task automatic model_edge();
        int d;
        bit fd;
        logic [3:0] nb;
        if (!rst_n) begin
            model_reset();
        end else begin
            d  = (t / R) % N;
            fd = en && (t % F == F - 1);
            nb = dv[4*d +: 4];
            if (en) begin
                e_an   = ~(4'b0001 << d);
                e_seg0 = is_dark(dv, dbl, d, 0) ? 7'h7F : ~hex7[nb];
                e_seg1 = is_dark(dv, dbl, d, 1) ? 7'h7F : ~hex7[nb];
                e_dp0  = is_dark(dv, dbl, d, 0) ? 1'b1 : ~ddp[d];
                e_dp1  = is_dark(dv, dbl, d, 1) ? 1'b1 : ~ddp[d];
            end else begin
                e_an = 4'hF; e_seg0 = 7'h7F; e_seg1 = 7'h7F;
                e_dp0 = 1'b1; e_dp1 = 1'b1;
            end
            e_fd = fd;
            if (fd && pend) begin
                dv = pv; ddp = pdp; dbl = pbl;
            end
            if (load) begin
                pv = value; pdp = dp_in; pbl = blank; pend = 1'b1;
            end else if (fd) begin
                pend = 1'b0;
            end
            if (en) t++;
            e_idx = 2'((t / R) % N);
        end
    endtask

    task automatic check_all();
        chk("seg", {9'd0, seg0}, {9'd0, e_seg0});
        chk("seg_lz", {9'd0, seg1}, {9'd0, e_seg1});
        chk("dp", {15'd0, dp0}, {15'd0, e_dp0});
        chk("dp_lz", {15'd0, dp1}, {15'd0, e_dp1});
        chk("an", {12'd0, an0}, {12'd0, e_an});
        chk("an_lz", {12'd0, an1}, {12'd0, e_an});
        chk("frame_done", {15'd0, fd0}, {15'd0, e_fd});
        chk("digit_idx", {14'd0, idx0}, {14'd0, e_idx});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic sync_to(input int m, input int r);
        int k;
        k = 0;
        while ((t % m) != r && k < 200) begin
            step();
            k++;
        end
        chk("sync", 16'((t % m) == r), 16'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] b);
        value = v; dp_in = d; blank = b; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        logic [31:0] r32;
        rst_n = 1'b1; en = 1'b0; load = 1'b0;
        value = '0; dp_in = '0; blank = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        step();
        step();
        #3 rst_n = 1'b1;
        en = 1'b1;

        // free-running scan of the reset-cleared buffer
        repeat (40) step();

        // value change lands only on a frame boundary
        do_load(16'h12AF, 4'b0100, 4'b0000);
        repeat (48) step();

        // load exactly on the wrap tick
        sync_to(F, F - 1);
        step();
        do_load(16'h1111, 4'b0000, 4'b0000);
        sync_to(F, F - 1);
        do_load(16'h2222, 4'b0000, 4'b0000);
        repeat (40) step();

        // leading-zero blanking
        do_load(16'h0050, 4'b0000, 4'b0000);
        repeat (40) step();
        do_load(16'h0000, 4'b0001, 4'b0000);
        repeat (40) step();

        // enable drop mid-digit, then resume
        do_load(16'hC0DE, 4'b1010, 4'b0010);
        sync_to(R, 1);
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        repeat (40) step();

        // asynchronous reset between edges during digit 2
        sync_to(F, 2 * R);
        step();
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        step();
        step();
        #3 rst_n = 1'b1;
        repeat (40) step();

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            r32   = $urandom;
            en    = ($urandom_range(0, 9) != 0);
            load  = ($urandom_range(0, 11) == 0);
            value = r32[15:0] >> (4 * $urandom_range(0, 4));
            dp_in = 4'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
        end
        load = 1'b0;
        en   = 1'b1;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
